alu_wb_seq: RTL
===============

# alu_wb_seq

Writeback sequencer directly downstream of the 16-bit ALU in the execute/writeback path. It holds one ALU result and drives the single-write-port register file. Multiply and divide produce a second word bound for R15, so the block serialises those into two write cycles and stalls upstream while it does. It also turns the ALU overflow flag into a precise exception instead of a register write.

## Interface
- No parameters; data width fixed at 16, register address width fixed at 4.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- inValid  in  1  an ALU result is presented this cycle
- inReady  out  1  block accepts; transfer occurs when inValid && inReady
- rdAddr  in  4  destination register (op1 field)
- resLo  in  16  word for rdAddr (ALU result bits 15:0)
- resHi  in  16  word for R15 (ALU R15 result); used only when dual=1
- dual  in  1  mult/div: write both rdAddr and R15
- ovExcep  in  1  ALU signed-overflow exception
- pcIn  in  16  PC of the instruction being presented
- rfWe  out  1  register-file write enable
- rfAddr  out  4  register-file write address
- rfData  out  16  register-file write data
- excValid  out  1  one-cycle overflow exception pulse
- epc  out  16  PC of the faulting instruction; holds until next exception

## Operation
- States: IDLE, WR_LO, WR_HI, EXC. All outputs registered except inReady (decoded from state).
- inReady = 1 in IDLE, WR_HI, and WR_LO with dual_q=0; 0 in WR_LO with dual_q=1 and in EXC.
- On accept: latch rdAddr, resLo, resHi, dual, pcIn. Next state is EXC if overflow is flagged (see Configuration), else WR_LO.
- WR_LO: rfWe=1, rfAddr=rd_q, rfData=lo_q. If dual_q, next state WR_HI. Else IDLE, or WR_LO/EXC when a new accept occurs the same cycle.
- WR_HI: rfWe=1, rfAddr=4'hF, rfData=hi_q. Exits to IDLE, or to WR_LO/EXC on a same-cycle accept.
- EXC: rfWe=0, excValid=1, epc=pc_q. Always returns to IDLE. The faulting result is never written.
- Dual op with rdAddr=15: both writes issue in order; R15 ends holding resHi.
- No arithmetic is performed; data passes through bit-exact.

## Timing
- Reset values: rfWe=0, rfAddr=0, rfData=0, excValid=0, epc=0, state=IDLE; held results cleared.
- Single write: accept in cycle N, rfWe high in N+1.
- Dual write: accept in N, rdAddr write in N+1, R15 write in N+2.
- Throughput: one single-write op per cycle back-to-back; dual op occupies 2 cycles; exception occupies 1 cycle.
- inReady does not depend on inValid, so there is no combinational loop.
- Reset asserted mid-sequence (WR_LO with dual pending, or EXC) aborts immediately. The pending R15 write and exception pulse are lost.

## Configuration
- ALU_WB_OVF_EXCEP_EN defined: ovExcep=1 at accept routes to EXC, suppresses the write, pulses excValid and loads epc.
- Not defined: ovExcep is ignored. The wrapped result is written normally, excValid is tied 0, epc is tied 0, and EXC is unreachable.

## Structure
- Shared package: state enumeration, constant R15 address 4'hF, data width 16, register address width 4.
- Single flat module; no sub-module is natural. The holding register and FSM are small enough to sit inline.

## Test plan
- Add result: rdAddr=3, resLo=16'h1234, dual=0 -> next cycle rfWe=1, rfAddr=3, rfData=16'h1234; inReady stays 1.
- Multiply: rdAddr=2, resLo=16'h5678, resHi=16'h0001, dual=1 with a second op presented -> cycle+1 writes R2=5678 with inReady=0; cycle+2 writes R15=0001 and accepts the second op.
- Back-to-back singles: 4 ops on consecutive cycles (R1..R4) -> 4 consecutive writes, no bubbles.
- Overflow with macro: ovExcep=1, pcIn=16'h0040 -> no rfWe; excValid pulses 1 cycle; epc=16'h0040; inReady=0 that cycle. Without the macro -> normal write, excValid=0.
- Dual op with rdAddr=15, resLo=AAAA, resHi=5555 -> R15=AAAA then R15=5555.
- Reset pulse during WR_LO of a dual op -> all outputs zero immediately; no R15 write afterwards; inReady=1 after release.

Source files
------------

// File: rtl/alu_wb_seq_pkg.sv
// Shared types and constants for the ALU writeback sequencer.
package alu_wb_seq_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] R15_ADDR = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR_LO = 2'd1,
    S_WR_HI = 2'd2,
    S_EXC   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/alu_wb_seq.sv
// Writeback sequencer: serialises dual-word ALU results into the single-port
// register file and converts overflow into a precise exception (ALU_WB_OVF_EXCEP_EN).
//
// state   | meaning
// S_IDLE  | nothing pending, ready for a result
// S_WR_LO | writing rdAddr word; holds upstream if an R15 word follows
// S_WR_HI | writing the R15 word of a mult/div
// S_EXC   | overflow exception pulse, result discarded
module alu_wb_seq
  import alu_wb_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] res_lo_i,
  input  logic [DATA_W-1:0] res_hi_i,
  input  logic              dual_i,
  input  logic              ov_excep_i,
  input  logic [DATA_W-1:0] pc_in_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_data_o,
  output logic              exc_valid_o,
  output logic [DATA_W-1:0] epc_o
);

  wb_state_t         state_q;
  logic              dual_q;
  logic [DATA_W-1:0] hi_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic              accept;
  logic              ovf;

`ifdef ALU_WB_OVF_EXCEP_EN
  logic              exc_valid_q;
  logic [DATA_W-1:0] epc_q;

  assign ovf         = ov_excep_i;
  assign exc_valid_o = exc_valid_q;
  assign epc_o       = epc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_valid_q <= 1'b0;
      epc_q       <= '0;
    end else begin
      exc_valid_q <= accept && ovf;
      if (accept && ovf) epc_q <= pc_in_i;
    end
  end
`else
  logic unused_ovf_inputs;

  assign unused_ovf_inputs = ov_excep_i ^ (^pc_in_i);
  assign ovf               = 1'b0;
  assign exc_valid_o       = 1'b0;
  assign epc_o             = '0;
`endif

  // Ready is a pure state decode so it never depends on in_valid_i.
  always_comb begin
    in_ready_o = 1'b1;
    case (state_q)
      S_WR_LO: in_ready_o = !dual_q;
      S_EXC:   in_ready_o = 1'b0;
      default: in_ready_o = 1'b1;
    endcase
  end

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      dual_q    <= 1'b0;
      hi_q      <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      state_q <= S_IDLE;
      if (accept) begin
        dual_q <= dual_i;
        hi_q   <= res_hi_i;
        if (ovf) begin
          state_q <= S_EXC;
        end else begin
          state_q   <= S_WR_LO;
          rf_we_q   <= 1'b1;
          rf_addr_q <= rd_addr_i;
          rf_data_q <= res_lo_i;
        end
      end else if (state_q == S_WR_LO && dual_q) begin
        state_q   <= S_WR_HI;
        rf_we_q   <= 1'b1;
        rf_addr_q <= R15_ADDR;
        rf_data_q <= hi_q;
      end
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_addr_o = rf_addr_q;
  assign rf_data_o = rf_data_q;

endmodule
